mc_controller: RTL
==================

Name: mc_controller

Overview:
- Multicycle sequencing controller for the 8-bit-data / 16-bit-instruction CPU datapath.
- Replaces the single-cycle decode with a Moore FSM that steps one shared-memory datapath through fetch, decode, execute, memory and writeback.
- Fields used: opcode = instr[15:12], funct = instr[3:0].
- Adds a memory-ready handshake so instruction fetch and data access can stall on slow memory.

Parameters:
- OPW, 4, opcode width.
- FW, 4, funct width.
- SW, 4, width of the state debug output.

Ports:
- clk, input, 1, system clock; all state changes on rising edge.
- reset, input, 1, asynchronous, active-high; forces state to FETCH immediately.
- op, input, OPW, opcode from instruction register.
- funct, input, FW, funct from instruction register.
- zero, input, 1, ALU zero flag.
- mem_ready, input, 1, memory has completed the current read or write this cycle.
- pcwrite, output, 1, unconditional PC load.
- branch, output, 1, PC load qualified by zero (datapath loads PC when pcwrite | (branch & zero)).
- iord, output, 1, memory address select: 0 = PC, 1 = ALUOut.
- memwrite, output, 1, memory write strobe.
- irwrite, output, 1, instruction register load.
- memtoreg, output, 1, register writeback select: 1 = MDR, 0 = ALUOut.
- regdst, output, 1, destination select: 1 = rd (R-type), 0 = rt.
- regwrite, output, 1, register file write enable.
- alusrca, output, 1, ALU A select: 0 = PC, 1 = register A.
- alusrcb, output, 2, ALU B select: 00 = B, 01 = constant 1, 10 = sign-extended immediate.
- pcsrc, output, 2, PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- alucontrol, output, 3, ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- illegal_op, output, 1, one-cycle pulse when an undefined opcode or funct is decoded.
- state, output, SW, current state encoding (debug).

Behaviour:
- Opcodes: 0000 R-type, 0001 lw, 0010 sw, 0011 beq, 0100 addi, 0101 j; all others are illegal.
- R-type funct: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 slt; all others are illegal.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEXE=6, ALUWB=7, ADDIEXE=8, ADDIWB=9, BEQ=10, JMP=11.
- Outputs are combinational from state only (Moore), except the mem_ready qualification noted below.
- Every signal not listed for a state is 0; alucontrol defaults to 010.
- While reset is high:
  - state = 0.
  - pcwrite, branch, memwrite, irwrite, regwrite, illegal_op = 0.
  - iord = 0, alusrca = 0, alusrcb = 01, pcsrc = 00, alucontrol = 010.
- FETCH:
  - iord = 0, alusrcb = 01, alucontrol = add.
  - irwrite = pcwrite = mem_ready.
  - Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE:
  - alusrcb = 10, alucontrol = add (precomputes the branch target).
  - Next state: R-type → RTEXE; lw/sw → MEMADR; beq → BEQ; addi → ADDIEXE; j → JMP.
  - Illegal opcode or illegal R-type funct: illegal_op = 1 for this cycle, next state FETCH, no architectural write.
- MEMADR: alusrca = 1, alusrcb = 10, add. Next: lw → MEMRD, sw → MEMWR.
- MEMRD: iord = 1. Holds until mem_ready, then MEMWB.
- MEMWB: regwrite = 1, memtoreg = 1, regdst = 0. Next FETCH.
- MEMWR:
  - iord = 1, memwrite = 1 held high every cycle in the state.
  - Holds until mem_ready, then FETCH.
  - Exactly one write is committed, on the mem_ready cycle.
- RTEXE: alusrca = 1, alusrcb = 00, alucontrol from funct. Next ALUWB.
- ALUWB: regwrite = 1, regdst = 1, memtoreg = 0. Next FETCH.
- ADDIEXE: alusrca = 1, alusrcb = 10, add. Next ADDIWB.
- ADDIWB: regwrite = 1, regdst = 0, memtoreg = 0. Next FETCH.
- BEQ:
  - alusrca = 1, alusrcb = 00, sub, pcsrc = 01, branch = 1.
  - Next FETCH regardless of zero.
- JMP: pcsrc = 10, pcwrite = 1. Next FETCH.
- Cycle counts with mem_ready always high:
  - lw = 5.
  - sw = 4.
  - R-type = 4.
  - addi = 4.
  - beq = 3.
  - j = 3.
  - Each wait cycle (mem_ready low in FETCH, MEMRD or MEMWR) adds 1.
- mem_ready is ignored in every state other than FETCH, MEMRD and MEMWR.
- Reset mid-instruction:
  - Returns to FETCH asynchronously; any in-progress memwrite or regwrite deasserts immediately.
  - No partial instruction resumes after reset.
- Unreachable state encodings (12–15) go to FETCH on the next edge with all write enables 0.

Test Plan:
- Reset asserted mid-MEMWR (memwrite = 1) → memwrite drops to 0 the same cycle without a clock edge; state = 0; after release the first edge with mem_ready = 1 pulses irwrite = pcwrite = 1.
- lw (op = 0001), mem_ready = 1 → state sequence 0,1,2,3,4,0; regwrite = 1 and memtoreg = 1 only in state 4; total 5 cycles.
- sw (op = 0010) with mem_ready low for 3 cycles in MEMWR → memwrite high for 4 consecutive cycles, state leaves 5 on the 4th; no regwrite at any point.
- R-type sub (op = 0000, funct = 0001) → RTEXE shows alucontrol = 110 and alusrcb = 00; ALUWB shows regwrite = 1 and regdst = 1.
- beq (op = 0011) run with zero = 1, then with zero = 0 → branch = 1 and pcsrc = 01 in state 10 in both runs; pcwrite = 0; next state 0 in both runs.
- Illegal op = 1111, then op = 0000 with funct = 1010 → illegal_op pulses for 1 cycle in DECODE; state returns to 0; regwrite, memwrite and pcwrite all stay 0.

Source files
------------

// File: rtl/mc_controller_if.sv
// Control bundle between the multicycle sequencer (master) and the datapath (slave).
// Instruction fields and status flow to the sequencer; strobes and selects flow back.
interface mc_controller_if #(
  parameter int OPW = 4,
  parameter int FW  = 4,
  parameter int SW  = 4
);
  logic [OPW-1:0] op;
  logic [FW-1:0]  funct;
  logic           zero;
  logic           mem_ready;

  logic           pcwrite;
  logic           branch;
  logic           iord;
  logic           memwrite;
  logic           irwrite;
  logic           memtoreg;
  logic           regdst;
  logic           regwrite;
  logic           alusrca;
  logic [1:0]     alusrcb;
  logic [1:0]     pcsrc;
  logic [2:0]     alucontrol;
  logic           illegal_op;
  logic [SW-1:0]  state;

  modport master (
    input  op, funct, zero, mem_ready,
    output pcwrite, branch, iord, memwrite, irwrite, memtoreg, regdst, regwrite,
           alusrca, alusrcb, pcsrc, alucontrol, illegal_op, state
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  pcwrite, branch, iord, memwrite, irwrite, memtoreg, regdst, regwrite,
           alusrca, alusrcb, pcsrc, alucontrol, illegal_op, state
  );
endinterface

// File: rtl/mc_controller.sv
// Moore sequencer stepping a shared-memory datapath through fetch/decode/execute/memory/writeback,
// stalling on mem_ready during instruction fetch and data access.
module mc_controller #(
  parameter int OPW = 4,
  parameter int FW  = 4,
  parameter int SW  = 4
) (
  input  logic             clk,
  input  logic             reset,
  mc_controller_if.master  bus
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,  DECODE = 4'd1,  MEMADR  = 4'd2, MEMRD  = 4'd3,
    MEMWB   = 4'd4,  MEMWR  = 4'd5,  RTEXE   = 4'd6, ALUWB  = 4'd7,
    ADDIEXE = 4'd8,  ADDIWB = 4'd9,  BEQ     = 4'd10, JMP   = 4'd11
  } state_t;

  localparam logic [OPW-1:0] OP_RTYPE = OPW'(0);
  localparam logic [OPW-1:0] OP_LW    = OPW'(1);
  localparam logic [OPW-1:0] OP_SW    = OPW'(2);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(3);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(4);
  localparam logic [OPW-1:0] OP_J     = OPW'(5);

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t     state_q;
  logic       illegal;
  logic [2:0] rtype_alu;
  logic       funct_ok;
  logic       unused_zero;

  // The sequencer never consults the zero flag: the datapath qualifies branch with it.
  assign unused_zero = bus.zero;

  always_comb begin
    rtype_alu = ALU_ADD;
    funct_ok  = 1'b1;
    case (bus.funct)
      FW'(0):  rtype_alu = ALU_ADD;
      FW'(1):  rtype_alu = ALU_SUB;
      FW'(2):  rtype_alu = ALU_AND;
      FW'(3):  rtype_alu = ALU_OR;
      FW'(4):  rtype_alu = ALU_SLT;
      default: funct_ok  = 1'b0;
    endcase
  end

  assign illegal = (bus.op > OP_J) || ((bus.op == OP_RTYPE) && !funct_ok);

  // NOTE: state is updated with non-blocking assignments so every reader samples the pre-edge value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      case (state_q)
        FETCH:   if (bus.mem_ready) state_q <= DECODE;
        DECODE: begin
          if (illegal)                 state_q <= FETCH;
          else begin
            case (bus.op)
              OP_RTYPE:       state_q <= RTEXE;
              OP_LW, OP_SW:   state_q <= MEMADR;
              OP_BEQ:         state_q <= BEQ;
              OP_ADDI:        state_q <= ADDIEXE;
              default:        state_q <= JMP;
            endcase
          end
        end
        MEMADR:  state_q <= (bus.op == OP_SW) ? MEMWR : MEMRD;
        MEMRD:   if (bus.mem_ready) state_q <= MEMWB;
        MEMWR:   if (bus.mem_ready) state_q <= FETCH;
        RTEXE:   state_q <= ALUWB;
        ADDIEXE: state_q <= ADDIWB;
        default: state_q <= FETCH;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred for unlisted states.
  always_comb begin
    bus.pcwrite    = 1'b0;
    bus.branch     = 1'b0;
    bus.iord       = 1'b0;
    bus.memwrite   = 1'b0;
    bus.irwrite    = 1'b0;
    bus.memtoreg   = 1'b0;
    bus.regdst     = 1'b0;
    bus.regwrite   = 1'b0;
    bus.alusrca    = 1'b0;
    bus.alusrcb    = 2'b00;
    bus.pcsrc      = 2'b00;
    bus.alucontrol = ALU_ADD;
    bus.illegal_op = 1'b0;
    case (state_q)
      FETCH: begin
        bus.alusrcb = 2'b01;
        // Reset holds state at FETCH, so gating here keeps the fetch strobes quiet during reset.
        bus.irwrite = bus.mem_ready & ~reset;
        bus.pcwrite = bus.mem_ready & ~reset;
      end
      DECODE: begin
        bus.alusrcb    = 2'b10;
        bus.illegal_op = illegal;
      end
      MEMADR, ADDIEXE: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
      end
      MEMRD:  bus.iord = 1'b1;
      MEMWB: begin
        bus.regwrite = 1'b1;
        bus.memtoreg = 1'b1;
      end
      MEMWR: begin
        bus.iord     = 1'b1;
        bus.memwrite = 1'b1;
      end
      RTEXE: begin
        bus.alusrca    = 1'b1;
        bus.alucontrol = rtype_alu;
      end
      ALUWB: begin
        bus.regwrite = 1'b1;
        bus.regdst   = 1'b1;
      end
      ADDIWB: bus.regwrite = 1'b1;
      BEQ: begin
        bus.alusrca    = 1'b1;
        bus.alucontrol = ALU_SUB;
        bus.pcsrc      = 2'b01;
        bus.branch     = 1'b1;
      end
      JMP: begin
        bus.pcsrc   = 2'b10;
        bus.pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.state = SW'(state_q);

endmodule
